// File: rtl/dmem_axi_pkg.sv
// Shared constants and types for the AXI4-Lite data-memory master.
// Bus response codes, load/store size encodings and FSM states.
package dmem_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } dmemState_e;

    function automatic logic respIsErr(input logic [1:0] resp);
        logic isErr;
        isErr = 1'b0;
        unique case (resp)
            RESP_OKAY, RESP_EXOKAY:   isErr = 1'b0;
            RESP_SLVERR, RESP_DECERR: isErr = 1'b1;
        endcase
        return isErr;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; also flags accesses not aligned to their size.
module mem_align
    import dmem_axi_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] storeData,
    input  logic [31:0] busRdata,
    output logic [31:0] busWdata,
    output logic [3:0]  busWstrb,
    output logic [31:0] loadData,
    output logic        misaligned
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    always_comb begin
        ldByte     = busRdata[{addrLo, 3'b000} +: 8];
        ldHalf     = addrLo[1] ? busRdata[31:16] : busRdata[15:0];
        busWdata   = storeData;
        busWstrb   = 4'hF;
        loadData   = busRdata;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                busWdata = {4{storeData[7:0]}};
                busWstrb = 4'b0001 << addrLo;
                loadData = {{24{ldByte[7] & ~funct3[2]}}, ldByte};
            end
            F3_H, F3_HU: begin
                busWdata   = {2{storeData[15:0]}};
                busWstrb   = 4'b0011 << {addrLo[1], 1'b0};
                loadData   = {{16{ldHalf[15] & ~funct3[2]}}, ldHalf};
                misaligned = addrLo[0];
            end
            default: misaligned = |addrLo;
        endcase
    end

endmodule

// File: rtl/axi_lite_dmem_master.sv
// MEM-stage bridge: one single-beat AXI4-Lite transaction per load/store,
// stalling the pipeline until the slave responds.
module axi_lite_dmem_master
    import dmem_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [2:0]        funct3_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [DATA_W-1:0] wdata_m,
    output logic [DATA_W-1:0] rdata_m,
    output logic              stall_m,
    output logic              done_m,
    output logic              err_m,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    if (DATA_W != 32) begin : gDataWCheck
        $error("axi_lite_dmem_master: DATA_W must be 32");
    end

    dmemState_e state, stateNext;

    logic [ADDR_W-1:0] addrReg;
    logic [2:0]        f3Reg;
    logic [DATA_W-1:0] wdataReg;
    logic [DATA_W-1:0] rdataReg;
    logic [3:0]        wstrbReg;
    logic              awPend;
    logic              wPend;
    logic              errReg;

    logic        isIdle;
    logic        req;
    logic [2:0]  alF3;
    logic [1:0]  alAddr;
    logic [31:0] alWdata;
    logic [31:0] alLoad;
    logic [3:0]  alWstrb;
    logic        alMis;

    assign isIdle = (state == IDLE);
    assign req    = mem_read_m | mem_write_m;

    // Request side is decoded live in IDLE; load extension uses the latched access.
    assign alF3   = isIdle ? funct3_m : f3Reg;
    assign alAddr = isIdle ? addr_m[1:0] : addrReg[1:0];

    mem_align uAlign (
        .funct3     (alF3),
        .addrLo     (alAddr),
        .storeData  (wdata_m),
        .busRdata   (m_axi_rdata),
        .busWdata   (alWdata),
        .busWstrb   (alWstrb),
        .loadData   (alLoad),
        .misaligned (alMis)
    );

    assign m_axi_awaddr  = {addrReg[ADDR_W-1:2], 2'b00};
    assign m_axi_araddr  = {addrReg[ADDR_W-1:2], 2'b00};
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = (state == WR) & awPend;
    assign m_axi_wvalid  = (state == WR) & wPend;
    assign m_axi_wdata   = wdataReg;
    assign m_axi_wstrb   = wstrbReg;
    assign m_axi_bready  = (state == WR_RESP);
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_rready  = (state == RD_DATA);

    assign done_m  = (state == DONE);
    assign err_m   = done_m & errReg;
    assign rdata_m = rdataReg;

    // Masked by reset so a held request does not stall while held in reset.
    assign stall_m = reset & ((isIdle & req) | ~(isIdle | done_m));

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (mem_write_m) begin
                    stateNext = alMis ? DONE : WR;
                end else if (mem_read_m) begin
                    stateNext = alMis ? DONE : RD_ADDR;
                end
            end
            WR: begin
                if ((~awPend | m_axi_awready) & (~wPend | m_axi_wready)) begin
                    stateNext = WR_RESP;
                end
            end
            WR_RESP: if (m_axi_bvalid) stateNext = DONE;
            RD_ADDR: if (m_axi_arready) stateNext = RD_DATA;
            RD_DATA: if (m_axi_rvalid) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addrReg  <= '0;
            f3Reg    <= '0;
            wdataReg <= '0;
            wstrbReg <= '0;
            rdataReg <= '0;
            awPend   <= 1'b0;
            wPend    <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            state <= stateNext;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addrReg  <= addr_m;
                        f3Reg    <= funct3_m;
                        wdataReg <= alWdata;
                        wstrbReg <= alWstrb;
                        errReg   <= alMis;
                        awPend   <= mem_write_m & ~alMis;
                        wPend    <= mem_write_m & ~alMis;
                    end
                end
                WR: begin
                    if (m_axi_awready) awPend <= 1'b0;
                    if (m_axi_wready) wPend <= 1'b0;
                end
                WR_RESP: begin
                    if (m_axi_bvalid) errReg <= respIsErr(m_axi_bresp);
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rdataReg <= alLoad;
                        errReg   <= respIsErr(m_axi_rresp);
                    end
                end
                default: ;
            endcase
        end
    end

    // Decode never issues a load and a store together.
    assert property (@(posedge clk) disable iff (!reset)
        !(mem_read_m && mem_write_m));

endmodule

// File: tb/tb_axi_lite_dmem_master.sv
// Directed bench for axi_lite_dmem_master with a delay-programmable slave
// and a transaction-level model of latency, lanes and load extension.
`timescale 1ns/1ps
module tb_axi_lite_dmem_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read_m = 1'b0;
    logic        mem_write_m = 1'b0;
    logic [2:0]  funct3_m = 3'b0;
    logic [31:0] addr_m = 32'h0;
    logic [31:0] wdata_m = 32'h0;
    logic [31:0] rdata_m;
    logic        stall_m, done_m, err_m;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi_lite_dmem_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .addr_m(addr_m), .wdata_m(wdata_m),
        .rdata_m(rdata_m), .stall_m(stall_m), .done_m(done_m), .err_m(err_m),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Slave: each ready/valid comes after a programmable number of cycles.
    int arD = 0, rD = 0, awD = 0, wD = 0, bD = 0;
    logic [31:0] sRdata = 32'h0;
    logic [1:0]  sResp = 2'b00;
    int   arCnt, awCnt, wCnt, rWait, bWait;
    logic rPend, bPend, awGot, wGot, awDone, wDone;

    assign m_axi_arready = m_axi_arvalid && (arCnt >= arD);
    assign m_axi_awready = m_axi_awvalid && (awCnt >= awD);
    assign m_axi_wready  = m_axi_wvalid && (wCnt >= wD);
    assign m_axi_rvalid  = rPend && (rWait == 0);
    assign m_axi_rdata   = m_axi_rvalid ? sRdata : 32'h0;
    assign m_axi_rresp   = m_axi_rvalid ? sResp : 2'b00;
    assign m_axi_bvalid  = bPend && (bWait == 0);
    assign m_axi_bresp   = m_axi_bvalid ? sResp : 2'b00;
    assign awDone = awGot || (m_axi_awvalid && m_axi_awready);
    assign wDone  = wGot || (m_axi_wvalid && m_axi_wready);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            arCnt <= 0; awCnt <= 0; wCnt <= 0; rWait <= 0; bWait <= 0;
            rPend <= 1'b0; bPend <= 1'b0; awGot <= 1'b0; wGot <= 1'b0;
        end else begin
            arCnt <= (m_axi_arvalid && !m_axi_arready) ? arCnt + 1 : 0;
            awCnt <= (m_axi_awvalid && !m_axi_awready) ? awCnt + 1 : 0;
            wCnt  <= (m_axi_wvalid && !m_axi_wready) ? wCnt + 1 : 0;
            if (m_axi_arvalid && m_axi_arready) begin
                rPend <= 1'b1; rWait <= rD;
            end else if (m_axi_rvalid && m_axi_rready) begin
                rPend <= 1'b0;
            end else if (rPend && rWait > 0) begin
                rWait <= rWait - 1;
            end
            if (awDone && wDone) begin
                bPend <= 1'b1; bWait <= bD; awGot <= 1'b0; wGot <= 1'b0;
            end else begin
                awGot <= awDone; wGot <= wDone;
            end
            if (m_axi_bvalid && m_axi_bready) bPend <= 1'b0;
            else if (bPend && bWait > 0) bWait <= bWait - 1;
        end
    end

    int vectors = 0;
    int misc = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: access size, alignment, lane placement and extension.
    function automatic int sizeOf(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic isMis(input logic [2:0] f3, input logic [31:0] a);
        return (a % sizeOf(f3)) != 0;
    endfunction

    function automatic logic [31:0] laneData(input logic [2:0] f3,
                                             input logic [31:0] d);
        logic [31:0] r;
        int s;
        s = sizeOf(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] laneStrb(input logic [2:0] f3,
                                            input logic [31:0] a);
        int m;
        m = ((1 << sizeOf(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] loadVal(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] w);
        int s;
        logic [31:0] m, r;
        s = sizeOf(f3);
        m = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*s)) - 32'd1);
        r = (w >> (8*(a % 4))) & m;
        if (f3[2] == 1'b0 && s < 4 && r[8*s-1]) r = r | ~m;
        return r;
    endfunction

    logic        active = 1'b0;
    int          k, L;
    int          expArCyc, expAwCyc, expWCyc, expBHs, expRHs;
    int          arCyc, awCyc, wCyc, bHs, rHs, doneK;
    logic [31:0] expAddr, expWdata, expRdata, lastRdata = 32'h0;
    logic [3:0]  expWstrb;
    logic        expErr, seenErr;
    logic [31:0] seenRdata, seenAddr, seenWdata;
    logic [3:0]  seenWstrb;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_stall", {31'b0, stall_m}, 32'd0);
            chk("rst_done", {31'b0, done_m}, 32'd0);
            chk("rst_err", {31'b0, err_m}, 32'd0);
            chk("rst_valids", {27'b0, m_axi_arvalid, m_axi_awvalid,
                m_axi_wvalid, m_axi_rready, m_axi_bready}, 32'd0);
            chk("rst_rdata", rdata_m, 32'd0);
        end else if (active) begin
            chk("stall", {31'b0, stall_m}, {31'b0, k < L});
            chk("done", {31'b0, done_m}, {31'b0, k == L});
            if (m_axi_arvalid) begin
                arCyc++;
                chk("araddr", m_axi_araddr, expAddr);
            end
            if (m_axi_awvalid) begin
                awCyc++;
                seenAddr = m_axi_awaddr;
                chk("awaddr", m_axi_awaddr, expAddr);
            end
            if (m_axi_wvalid) begin
                wCyc++;
                seenWdata = m_axi_wdata;
                seenWstrb = m_axi_wstrb;
                chk("wdata", m_axi_wdata, expWdata);
                chk("wstrb", {28'b0, m_axi_wstrb}, {28'b0, expWstrb});
            end
            if (m_axi_bvalid && m_axi_bready) bHs++;
            if (m_axi_rvalid && m_axi_rready) rHs++;
            if (k == L) begin
                doneK = k;
                seenErr = err_m;
                seenRdata = rdata_m;
                chk("err_m", {31'b0, err_m}, {31'b0, expErr});
                chk("rdata_m", rdata_m, expRdata);
                chk("ar_cycles", arCyc, expArCyc);
                chk("aw_cycles", awCyc, expAwCyc);
                chk("w_cycles", wCyc, expWCyc);
                chk("b_handshakes", bHs, expBHs);
                chk("r_handshakes", rHs, expRHs);
                lastRdata = expRdata;
                active = 1'b0;
            end
            k++;
        end else begin
            chk("idle_stall", {31'b0, stall_m}, 32'd0);
            chk("idle_done", {31'b0, done_m}, 32'd0);
            chk("idle_valids", {29'b0, m_axi_arvalid, m_axi_awvalid,
                m_axi_wvalid}, 32'd0);
        end
    end

    task automatic setup(input bit isWr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] slvRdata, input logic [1:0] resp,
                         input int dA, input int dW, input int dR);
        logic mis;
        mis = isMis(f3, a);
        arD = dA; awD = dA; wD = dW; rD = dR; bD = dR;
        sRdata = slvRdata; sResp = resp;
        expAddr = {a[31:2], 2'b00};
        expWdata = laneData(f3, d);
        expWstrb = laneStrb(f3, a);
        expErr = mis || (resp >= 2'd2);
        expRdata = (!isWr && !mis) ? loadVal(f3, a, slvRdata) : lastRdata;
        if (mis) L = 1;
        else if (isWr) L = 1 + ((dA > dW ? dA : dW) + 1) + (1 + dR);
        else L = 1 + (1 + dA) + (1 + dR);
        expArCyc = (!isWr && !mis) ? 1 + dA : 0;
        expAwCyc = (isWr && !mis) ? 1 + dA : 0;
        expWCyc  = (isWr && !mis) ? 1 + dW : 0;
        expBHs   = (isWr && !mis) ? 1 : 0;
        expRHs   = (!isWr && !mis) ? 1 : 0;
        arCyc = 0; awCyc = 0; wCyc = 0; bHs = 0; rHs = 0; k = 0;
        doneK = -1; seenErr = 1'bx; seenRdata = 'x;
        seenAddr = 'x; seenWdata = 'x; seenWstrb = 'x;
        @(posedge clk); #1;
        mem_write_m = isWr; mem_read_m = !isWr;
        funct3_m = f3; addr_m = a; wdata_m = d;
        active = 1'b1;
    endtask

    task automatic txn(input bit isWr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] slvRdata, input logic [1:0] resp,
                       input int dA, input int dW, input int dR);
        int n;
        setup(isWr, f3, a, d, slvRdata, resp, dA, dW, dR);
        n = 0;
        while (active && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("txn_bounded", {31'b0, active}, 32'd0);
        active = 1'b0;
        #1;
        mem_read_m = 1'b0;
        mem_write_m = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);

        txn(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2'b00, 0, 0, 0);
        chk("lw_rdata", seenRdata, 32'hDEADBEEF);
        chk("lw_latency", doneK, 32'd3);
        chk("lw_err", {31'b0, seenErr}, 32'd0);

        txn(1, 3'b000, 32'h203, 32'h0000_00A5, 32'h0, 2'b00, 0, 0, 0);
        chk("sb_awaddr", seenAddr, 32'h200);
        chk("sb_wstrb", {28'b0, seenWstrb}, 32'h8);
        chk("sb_wdata", seenWdata, 32'hA5A5A5A5);

        txn(1, 3'b010, 32'h204, 32'h1234_5678, 32'h0, 2'b00, 3, 0, 0);
        chk("sw_aw_hold", awCyc, 32'd4);
        chk("sw_w_hold", wCyc, 32'd1);
        chk("sw_bhs", bHs, 32'd1);

        txn(0, 3'b000, 32'h101, 32'h0, 32'h0000_8000, 2'b00, 0, 0, 0);
        chk("lb_sext", seenRdata, 32'hFFFFFF80);
        txn(0, 3'b100, 32'h101, 32'h0, 32'h0000_8000, 2'b00, 0, 0, 0);
        chk("lbu_zext", seenRdata, 32'h0000_0080);
        txn(0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 2'b00, 0, 0, 0);
        chk("lhu_zext", seenRdata, 32'h0000_8001);

        txn(0, 3'b010, 32'h102, 32'h0, 32'h5555_5555, 2'b00, 0, 0, 0);
        chk("lw_mis_err", {31'b0, seenErr}, 32'd1);
        chk("lw_mis_lat", doneK, 32'd1);
        chk("lw_mis_noar", arCyc, 32'd0);

        txn(0, 3'b010, 32'h108, 32'h0, 32'h1111_2222, 2'b10, 0, 0, 0);
        chk("lw_slverr", {31'b0, seenErr}, 32'd1);

        txn(1, 3'b001, 32'h0A2, 32'hBEEF_5555, 32'h0, 2'b11, 0, 2, 1);
        chk("sh_decerr", {31'b0, seenErr}, 32'd1);
        chk("sh_wstrb", {28'b0, seenWstrb}, 32'hC);
        chk("sh_wdata", seenWdata, 32'h5555_5555);

        txn(0, 3'b001, 32'h106, 32'h0, 32'h9ABC_0000, 2'b01, 1, 0, 2);
        chk("lh_sext", seenRdata, 32'hFFFF_9ABC);
        chk("lh_exokay", {31'b0, seenErr}, 32'd0);

        txn(1, 3'b001, 32'h201, 32'hFFFF_FFFF, 32'h0, 2'b00, 0, 0, 0);
        txn(1, 3'b010, 32'h20C, 32'hCAFE_F00D, 32'h0, 2'b00, 1, 1, 0);

        setup(0, 3'b010, 32'h300, 32'h0, 32'h7777_7777, 2'b00, 0, 0, 5);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_rready", {31'b0, m_axi_rready}, 32'd1);
        active = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_arvalid", {31'b0, m_axi_arvalid}, 32'd0);
        chk("abort_rready", {31'b0, m_axi_rready}, 32'd0);
        chk("abort_stall", {31'b0, stall_m}, 32'd0);
        lastRdata = 32'h0;
        @(posedge clk); #1;
        mem_read_m = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        repeat (3) @(posedge clk);

        txn(0, 3'b010, 32'h104, 32'h0, 32'h0BAD_CAFE, 2'b00, 0, 0, 0);
        chk("post_rst_lw", seenRdata, 32'h0BAD_CAFE);
        chk("post_rst_lat", doneK, 32'd3);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
